// File: rtl/conv2d_sched_if.sv
// conv2d_sched_if
//   Bundles the memory read buses, the engine cfg write port, the window
//   handshake and the snooped engine result handshake used by conv2d_sched.
//
//   master : scheduler side (drives read strobes, cfg writes, window)
//   slave  : memory/engine side (returns read data, win_ready, result snoop)
//
//   coef_rd_en/addr/data : coef memory read, data one cycle after the strobe
//   pix_rd_en/addr/data  : pixel memory read, data one cycle after the strobe
//   cfg_write/addr/wdata : engine configuration write
//   window/win_valid/win_ready : KxK window handshake toward the engine
//   eng_out_valid/ready  : engine result handshake, observed only
interface conv2d_sched_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int PIX_AW = 5,
  parameter int CFG_AW = 4
) ();

  logic                  coef_rd_en;
  logic [CFG_AW-1:0]     coef_rd_addr;
  logic [DATA_W-1:0]     coef_rd_data;
  logic                  pix_rd_en;
  logic [PIX_AW-1:0]     pix_rd_addr;
  logic [DATA_W-1:0]     pix_rd_data;
  logic                  cfg_write;
  logic [CFG_AW-1:0]     cfg_addr;
  logic [DATA_W-1:0]     cfg_wdata;
  logic [K*K*DATA_W-1:0] window;
  logic                  win_valid;
  logic                  win_ready;
  logic                  eng_out_valid;
  logic                  eng_out_ready;

  modport master (
    output coef_rd_en, coef_rd_addr, input coef_rd_data,
    output pix_rd_en, pix_rd_addr, input pix_rd_data,
    output cfg_write, cfg_addr, cfg_wdata,
    output window, win_valid, input win_ready,
    input eng_out_valid, eng_out_ready
  );

  modport slave (
    input coef_rd_en, coef_rd_addr, output coef_rd_data,
    input pix_rd_en, pix_rd_addr, output pix_rd_data,
    input cfg_write, cfg_addr, cfg_wdata,
    input window, win_valid, output win_ready,
    output eng_out_valid, eng_out_ready
  );

endinterface

// File: rtl/conv2d_sched.sv
// conv2d_sched
//   Sequences one conv2d_engine run: copies the K*K weights plus bias from
//   the coef memory into the engine cfg port, then walks every KxK window of
//   the stored image, fetching pixels into a window register and offering it
//   on the window handshake. Engine results are counted and done pulses once
//   all NUM_OUT results have been seen.
//
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : begin a run (accepted only in IDLE)
//   busy     : run in progress (LOAD through DRAIN)
//   done     : one-cycle pulse at the end of a run
//   bus      : conv2d_sched_if.master (memories, cfg port, window, result snoop)
//
//   Optional build macro CONV2D_SCHED_REUSE_EN: when a window advances within
//   the same row the register shifts left one column and only the new
//   rightmost column is fetched.
module conv2d_sched #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int NPARAM = K*K+1,
  parameter int PIX_AW = $clog2(IMG_W*IMG_H),
  parameter int CFG_AW = $clog2(NPARAM+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  conv2d_sched_if.master bus
);

  localparam int WIN_N   = K*K;
  localparam int NUM_OUT = (IMG_H-K+1)*(IMG_W-K+1);
  localparam int OUT_W   = $clog2(NUM_OUT+1);
  localparam int RD_W    = $clog2(WIN_N+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CFG_AW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [PIX_AW-1:0]     r0_q, r0_d, c0_q, c0_d;
  logic [PIX_AW-1:0]     kr_q, kr_d, kc_q, kc_d;
  logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic                  full_q, full_d;
  logic                  cap_en_q, cap_en_d;
  logic [RD_W-1:0]       cap_idx_q, cap_idx_d;
  logic [K*K*DATA_W-1:0] window_q, window_d;
  logic [OUT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [RD_W-1:0]       fetch_len;
  logic                  res_fire;
  logic                  last_win;

  assign bus.window = window_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign res_fire   = bus.eng_out_valid && bus.eng_out_ready;
  assign fetch_len  = full_q ? RD_W'(WIN_N) : RD_W'(K);
  assign last_win   = (r0_q == PIX_AW'(IMG_H-K)) && (c0_q == PIX_AW'(IMG_W-K));

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    r0_d      = r0_q;
    c0_d      = c0_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    cap_en_d  = 1'b0;
    cap_idx_d = cap_idx_q;
    window_d  = window_q;
    out_cnt_d = out_cnt_q;

    bus.coef_rd_en   = 1'b0;
    bus.coef_rd_addr = '0;
    bus.cfg_write    = 1'b0;
    bus.cfg_addr     = '0;
    bus.cfg_wdata    = '0;
    bus.pix_rd_en    = 1'b0;
    bus.pix_rd_addr  = '0;
    bus.win_valid    = 1'b0;

    // Results are only meaningful while windows are in flight.
    if (res_fire && (state_q == S_FETCH || state_q == S_ISSUE || state_q == S_DRAIN))
      out_cnt_d = out_cnt_q + OUT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end

      // Read on cycle i, write the returned word on cycle i+1.
      S_LOAD: begin
        if (ld_cnt_q < CFG_AW'(NPARAM)) begin
          bus.coef_rd_en   = 1'b1;
          bus.coef_rd_addr = ld_cnt_q;
        end
        if (ld_cnt_q != '0) begin
          bus.cfg_write = 1'b1;
          bus.cfg_addr  = ld_cnt_q - CFG_AW'(1);
          bus.cfg_wdata = bus.coef_rd_data;
        end
        ld_cnt_d = ld_cnt_q + CFG_AW'(1);
        if (ld_cnt_q == CFG_AW'(NPARAM)) begin
          state_d  = S_FETCH;
          ld_cnt_d = '0;
          r0_d     = '0;
          c0_d     = '0;
          kr_d     = '0;
          kc_d     = '0;
          rd_cnt_d = '0;
          full_d   = 1'b1;
        end
      end

      // A column-only fetch keeps kc pinned to K-1 and walks kr.
      S_FETCH: begin
        if (rd_cnt_q < fetch_len) begin
          bus.pix_rd_en   = 1'b1;
          bus.pix_rd_addr = (r0_q + kr_q) * PIX_AW'(IMG_W) + c0_q + kc_q;
          cap_en_d        = 1'b1;
          cap_idx_d       = RD_W'(kr_q * PIX_AW'(K) + kc_q);
          rd_cnt_d        = rd_cnt_q + RD_W'(1);
          if (full_q && (kc_q != PIX_AW'(K-1))) begin
            kc_d = kc_q + PIX_AW'(1);
          end else begin
            kr_d = kr_q + PIX_AW'(1);
            if (full_q)
              kc_d = '0;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        bus.win_valid = 1'b1;
        if (bus.win_ready) begin
          if (last_win) begin
            state_d = S_DRAIN;
          end else begin
            state_d  = S_FETCH;
            rd_cnt_d = '0;
            kr_d     = '0;
            if (c0_q == PIX_AW'(IMG_W-K)) begin
              c0_d   = '0;
              r0_d   = r0_q + PIX_AW'(1);
              full_d = 1'b1;
              kc_d   = '0;
            end else begin
              c0_d = c0_q + PIX_AW'(1);
`ifdef CONV2D_SCHED_REUSE_EN
              full_d = 1'b0;
              kc_d   = PIX_AW'(K-1);
              for (int i = 0; i < K; i++)
                for (int j = 0; j < K-1; j++)
                  window_d[(i*K+j)*DATA_W +: DATA_W] = window_q[(i*K+j+1)*DATA_W +: DATA_W];
`else
              full_d = 1'b1;
              kc_d   = '0;
`endif
            end
          end
        end
      end

      S_DRAIN: begin
        if (out_cnt_q == OUT_W'(NUM_OUT))
          state_d = S_DONE;
      end

      S_DONE: begin
        out_cnt_d = '0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Pixel data returns one cycle after its read; drop it into its slot.
    for (int e = 0; e < WIN_N; e++)
      if (cap_en_q && (cap_idx_q == RD_W'(e)))
        window_d[e*DATA_W +: DATA_W] = bus.pix_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ld_cnt_q  <= '0;
      r0_q      <= '0;
      c0_q      <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      rd_cnt_q  <= '0;
      full_q    <= 1'b1;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      window_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      r0_q      <= r0_d;
      c0_q      <= c0_d;
      kr_q      <= kr_d;
      kc_q      <= kc_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      cap_en_q  <= cap_en_d;
      cap_idx_q <= cap_idx_d;
      window_q  <= window_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_conv2d_sched.sv
// tb_conv2d_sched
//   Directed bench for conv2d_sched with the default 5x5 image / 3x3 kernel.
//   Models the coef and pixel memories (one-cycle read latency) and an engine
//   that returns one result a programmable number of cycles after each window
//   handshake. Build with CONV2D_SCHED_REUSE_EN defined to exercise column reuse.
module tb_conv2d_sched;

  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int PIX_AW = 5;
  localparam int CFG_AW = 4;
  localparam int LOGN   = 1024;
`ifdef CONV2D_SCHED_REUSE_EN
  localparam int EXP_PIX = 45;
`else
  localparam int EXP_PIX = 81;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  conv2d_sched_if #(.DATA_W(DATA_W), .K(K), .PIX_AW(PIX_AW), .CFG_AW(CFG_AW)) bus ();

  conv2d_sched #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] coef_mem [0:15];
  logic [DATA_W-1:0] pix_mem  [0:31];

  // Memory models: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.coef_rd_en) bus.coef_rd_data <= coef_mem[bus.coef_rd_addr];
    if (bus.pix_rd_en)  bus.pix_rd_data  <= pix_mem[bus.pix_rd_addr];
  end

  // Event logs, written only by the monitor below.
  int              cyc = 0;
  int              n_cfg = 0;
  int              n_hs = 0;
  int              n_done = 0;
  int              pix_reads = 0;
  int              done_cyc = 0;
  logic [3:0]      cfg_addr_log [0:LOGN-1];
  logic [7:0]      cfg_data_log [0:LOGN-1];
  int              cfg_cyc_log  [0:LOGN-1];
  logic [71:0]     win_log      [0:LOGN-1];
  int              hs_cyc_log   [0:LOGN-1];
  int              res_due [$];
  int              res_delay;
  logic            stray;

  // Mid-cycle monitor and engine model: drives the result handshake for
  // this cycle, then records what the DUT is doing in it.
  always @(negedge clk) begin
    cyc++;
    if (rst) res_due.delete();
    if (res_due.size() > 0 && res_due[0] == cyc) begin
      void'(res_due.pop_front());
      bus.eng_out_valid = 1'b1;
    end else begin
      bus.eng_out_valid = stray;
    end
    bus.eng_out_ready = bus.eng_out_valid;
    if (bus.cfg_write) begin
      if (n_cfg < LOGN) begin
        cfg_addr_log[n_cfg] = bus.cfg_addr;
        cfg_data_log[n_cfg] = bus.cfg_wdata;
        cfg_cyc_log[n_cfg]  = cyc;
      end
      n_cfg++;
    end
    if (bus.pix_rd_en) pix_reads++;
    if (bus.win_valid && bus.win_ready) begin
      if (n_hs < LOGN) begin
        win_log[n_hs]    = bus.window;
        hs_cyc_log[n_hs] = cyc;
      end
      n_hs++;
      res_due.push_back(cyc + res_delay);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // Expected window w: pixel at address a holds a+1.
  function automatic logic [71:0] expWin(input int w);
    logic [71:0] v;
    int r0, c0;
    r0 = w / (IMG_W-K+1);
    c0 = w % (IMG_W-K+1);
    v = '0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        v[(kr*K+kc)*8 +: 8] = 8'((r0+kr)*IMG_W + c0 + kc + 1);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic rst_v, input logic start_v, input logic ready_v, input int n);
    rst = rst_v;
    start = start_v;
    bus.win_ready = ready_v;
    tick(n);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitHs(input int target, input int budget, input string tag);
    int k = 0;
    while (n_hs < target && k < budget) begin tick(1); k++; end
    checkOutput(tag, n_hs >= target, 1'b1);
  endtask

  task automatic waitValid(input int budget, input string tag);
    int k = 0;
    while (bus.win_valid !== 1'b1 && k < budget) begin tick(1); k++; end
    checkOutput(tag, bus.win_valid, 1'b1);
  endtask

  task automatic waitDone(input int b_done, input int budget, input string tag);
    int k = 0;
    while (n_done == b_done && k < budget) begin tick(1); k++; end
    checkOutput(tag, n_done != b_done, 1'b1);
  endtask

  // Whole-run checks: cfg sequence, window contents/order, timing, reads.
  task automatic checkRun(input string tag, input int s, input int b_cfg, input int b_hs,
                          input int b_pix, input int b_done, input int gap);
    checkOutput({tag, "_cfg_count"}, n_cfg - b_cfg, 10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("%s_cfg%0d_addr", tag, i), cfg_addr_log[b_cfg+i], i);
      checkOutput($sformatf("%s_cfg%0d_data", tag, i), cfg_data_log[b_cfg+i], coef_mem[i]);
      checkOutput($sformatf("%s_cfg%0d_cyc", tag, i), cfg_cyc_log[b_cfg+i], s + 2 + i);
    end
    checkOutput({tag, "_win_count"}, n_hs - b_hs, 9);
    for (int w = 0; w < 9; w++)
      checkOutput($sformatf("%s_win%0d", tag, w), win_log[b_hs+w], expWin(w));
    checkOutput({tag, "_first_win_cyc"}, hs_cyc_log[b_hs], s + 22);
    checkOutput({tag, "_done_count"}, n_done - b_done, 1);
    checkOutput({tag, "_done_cyc"}, done_cyc, hs_cyc_log[b_hs+8] + gap);
    checkOutput({tag, "_pix_reads"}, pix_reads - b_pix, EXP_PIX);
  endtask

  initial begin
    int s, b_cfg, b_hs, b_pix, b_done;
    logic [7:0] coef_init [0:9];
    coef_init = '{8'd1, 8'd0, 8'hFF, 8'd1, 8'd0, 8'hFF, 8'd1, 8'd0, 8'hFF, 8'd0};
    for (int i = 0; i < 16; i++) coef_mem[i] = (i < 10) ? coef_init[i] : 8'd0;
    for (int i = 0; i < 32; i++) pix_mem[i] = 8'(i + 1);
    stray = 1'b0;
    res_delay = 1;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_strobes", {bus.coef_rd_en, bus.pix_rd_en, bus.cfg_write, bus.win_valid, done}, 5'b0);
    checkOutput("reset_window", bus.window, 72'd0);
    checkOutput("reset_addrs", {bus.coef_rd_addr, bus.pix_rd_addr, bus.cfg_addr, bus.cfg_wdata}, 21'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);

    $display("[TB] run A: basic");
    b_cfg = n_cfg; b_hs = n_hs; b_pix = pix_reads; b_done = n_done;
    s = cyc + 1;
    checkOutput("A_busy_before", busy, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    start = 1'b0;
    checkOutput("A_busy_rise", busy, 1'b1);
    checkOutput("A_first_coef_rd", {bus.coef_rd_en, bus.coef_rd_addr}, {1'b1, 4'd0});
    waitDone(b_done, 400, "A_done_timeout");
    checkRun("A", s, b_cfg, b_hs, b_pix, b_done, 3);
    checkOutput("A_idle_busy", busy, 1'b0);

    $display("[TB] run B: stall on window 4, delayed last result");
    tick(2);
    b_cfg = n_cfg; b_hs = n_hs; b_pix = pix_reads; b_done = n_done;
    s = cyc + 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    start = 1'b0;
    waitHs(b_hs + 3, 200, "B_hs3_timeout");
    bus.win_ready = 1'b0;
    waitValid(50, "B_stall_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("B_stall%0d_valid", k), bus.win_valid, 1'b1);
      checkOutput($sformatf("B_stall%0d_window", k), bus.window, expWin(3));
      checkOutput($sformatf("B_stall%0d_no_read", k), bus.pix_rd_en, 1'b0);
      tick(1);
    end
    bus.win_ready = 1'b1;
    waitHs(b_hs + 8, 200, "B_hs8_timeout");
    res_delay = 20;
    waitHs(b_hs + 9, 50, "B_hs9_timeout");
    tick(10);
    checkOutput("B_drain_busy", busy, 1'b1);
    checkOutput("B_drain_quiet", {done, bus.win_valid, bus.pix_rd_en, bus.coef_rd_en}, 4'b0);
    waitDone(b_done, 100, "B_done_timeout");
    res_delay = 1;
    checkRun("B", s, b_cfg, b_hs, b_pix, b_done, 22);

    $display("[TB] run C: start during ISSUE, reset mid-FETCH");
    tick(2);
    b_done = n_done;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    start = 1'b0;
    waitValid(60, "C_valid_timeout");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("C_start_ignored", {bus.win_valid, bus.cfg_write, bus.coef_rd_en, busy}, 4'b1001);
    bus.win_ready = 1'b1;
    tick(3);
    checkOutput("C_in_fetch", bus.pix_rd_en, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("C_rst_busy", busy, 1'b0);
    checkOutput("C_rst_strobes", {bus.coef_rd_en, bus.pix_rd_en, bus.cfg_write, bus.win_valid, done}, 5'b0);
    checkOutput("C_rst_window", bus.window, 72'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    checkOutput("C_no_done", n_done - b_done, 0);
    checkOutput("C_idle_after_rst", busy, 1'b0);

    $display("[TB] run D: fresh run with stray results in IDLE and LOAD");
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    b_cfg = n_cfg; b_hs = n_hs; b_pix = pix_reads; b_done = n_done;
    s = cyc + 1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    start = 1'b0;
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    waitDone(b_done, 400, "D_done_timeout");
    checkRun("D", s, b_cfg, b_hs, b_pix, b_done, 3);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
